// File: rtl/crc16_frame_tx.sv
// crc16_frame_tx: buffers one frame, streams it gap-free into a byte-wide CRC-16 engine, then
// replays it downstream with the CRC appended high byte first. Optional macro: CRC16_FRAME_CNT_EN.
module crc16_frame_tx #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [7:0]  crc_data,
    output logic        crc_data_valid,
    input  logic [15:0] crc_in,
`ifdef CRC16_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        ovf
);

    typedef enum logic [2:0] {IDLE, FILL, CALC, CAPT, SEND, CRC_HI, CRC_LO, DROP} state_t;

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_buf [DEPTH];
    logic [AW:0]   r_len, w_len_nxt;
    logic [AW:0]   r_sent, w_sent_nxt;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [7:0]    r_rd_data;
    logic          r_crc_vld, w_crc_vld_nxt;
    logic [15:0]   r_crc_q;
    logic          w_capture;
    logic [7:0]    r_out_data, w_out_byte;
    logic          r_out_valid, r_out_last, w_out_last_nxt;
    logic          w_out_load, w_out_clr;
    logic          r_ovf, w_ovf_nxt;
    logic          w_in_ready, w_in_hs, w_out_hs, w_wr_en, w_rd_last;
    logic [AW-1:0] w_wr_addr;

    assign w_in_hs   = in_valid & w_in_ready;
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_wr_addr = r_len[AW-1:0];
    assign w_rd_last = ({1'b0, r_rd_ptr} + 1'b1) == r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_ready     = 1'b0;
        w_wr_en        = 1'b0;
        w_len_nxt      = r_len;
        w_sent_nxt     = r_sent;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_crc_vld_nxt  = 1'b0;
        w_capture      = 1'b0;
        w_out_load     = 1'b0;
        w_out_clr      = 1'b0;
        w_out_byte     = r_rd_data;
        w_out_last_nxt = 1'b0;
        w_ovf_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                w_rd_ptr_nxt = '0;
                w_state_nxt  = FILL;
            end
            FILL: begin
                w_in_ready   = 1'b1;
                w_rd_ptr_nxt = '0;
                if (w_in_hs) begin
                    if (r_len == LEN_FULL) begin
                        // a byte beyond DEPTH is never stored; the frame is oversize
                        if (in_last) begin
                            w_ovf_nxt = 1'b1;
                            w_len_nxt = '0;
                        end else begin
                            w_state_nxt = DROP;
                        end
                    end else begin
                        w_wr_en   = 1'b1;
                        w_len_nxt = r_len + 1'b1;
                        if (in_last) begin
                            w_crc_vld_nxt = 1'b1;
                            w_state_nxt   = CALC;
                        end
                    end
                end
            end
            DROP: begin
                w_in_ready = 1'b1;
                if (w_in_hs && in_last) begin
                    w_ovf_nxt   = 1'b1;
                    w_len_nxt   = '0;
                    w_state_nxt = FILL;
                end
            end
            CALC: begin
                if (w_rd_last) begin
                    w_rd_ptr_nxt = '0;
                    w_state_nxt  = CAPT;
                end else begin
                    w_crc_vld_nxt = 1'b1;
                    w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
                end
            end
            CAPT: begin
                w_capture   = 1'b1;
                w_sent_nxt  = '0;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (!r_out_valid || out_ready) begin
                    w_out_load = 1'b1;
                    if (r_sent == r_len) begin
                        w_out_byte  = r_crc_q[15:8];
                        w_state_nxt = CRC_HI;
                    end else begin
                        w_sent_nxt   = r_sent + 1'b1;
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    end
                end
            end
            CRC_HI: begin
                if (w_out_hs) begin
                    w_out_load     = 1'b1;
                    w_out_byte     = r_crc_q[7:0];
                    w_out_last_nxt = 1'b1;
                    w_state_nxt    = CRC_LO;
                end
            end
            CRC_LO: begin
                if (w_out_hs) begin
                    w_out_clr   = 1'b1;
                    w_len_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[w_wr_addr] <= in_data;
    end

    // read port is registered; the bypass covers byte 0 arriving together with in_last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_sent      <= '0;
            r_rd_ptr    <= '0;
            r_rd_data   <= '0;
            r_crc_vld   <= 1'b0;
            r_crc_q     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_len     <= w_len_nxt;
            r_sent    <= w_sent_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_data <= (w_wr_en && (w_wr_addr == w_rd_ptr_nxt)) ? in_data : r_buf[w_rd_ptr_nxt];
            r_crc_vld <= w_crc_vld_nxt;
            r_ovf     <= w_ovf_nxt;
            if (w_capture) r_crc_q <= crc_in;
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_byte;
                r_out_last  <= w_out_last_nxt;
            end else if (w_out_clr) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef CRC16_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_frame_cnt <= '0;
        else if (r_state == CRC_LO && w_out_hs) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign in_ready       = w_in_ready;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;
    assign crc_data       = r_rd_data;
    assign crc_data_valid = r_crc_vld;
    assign ovf            = r_ovf;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Scoreboard bench for crc16_frame_tx at DEPTH=4 with a behavioural CRC-16/XMODEM engine
// (or a stub that returns 0xBEEF in the capture cycle). Honors CRC16_FRAME_CNT_EN.
`timescale 1ns/1ps
module tb_crc16_frame_tx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  crc_data;
    logic        crc_data_valid;
    logic [15:0] crc_in;
    logic        ovf;
`ifdef CRC16_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    crc16_frame_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .crc_data(crc_data), .crc_data_valid(crc_data_valid), .crc_in(crc_in),
`ifdef CRC16_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ovf_seen = 0;
    int t_last = 0;
    logic stub_mode = 1'b0;
    logic bp_mode = 1'b0;
    logic rdy_lvl = 1'b1;
    logic [7:0] fb [8];

    logic [8:0] q_out [$];
    logic [7:0] q_crc [$];
    int         q_run [$];
    int         q_lat [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, required nothing (t=%0t)", name, act, $time);
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // engine stand-in: state returns to zero whenever data_valid is low
    logic [15:0] eng_crc;
    logic        prev_cdv;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_crc  <= 16'h0000;
            prev_cdv <= 1'b0;
        end else begin
            prev_cdv <= crc_data_valid;
            eng_crc  <= crc_data_valid ? crc_step(eng_crc, crc_data) : 16'h0000;
        end
    end
    assign crc_in = stub_mode ? ((prev_cdv && !crc_data_valid) ? 16'hBEEF : 16'h0000) : eng_crc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = (ph % 4 == 0) || (ph % 4 == 3);
            else         out_ready = rdy_lvl;
            ph++;
        end
    end

    // monitor: pops expectations whenever the DUT presents something
    initial begin
        logic       pv, pr, pl;
        logic [7:0] pd;
        logic [8:0] e9;
        int run, gap, have_run;
        pv = 0; pr = 0; pl = 0; pd = 0; run = 0; gap = 0; have_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0; pr = 0; run = 0; gap = 0; have_run = 0;
            end else begin
                if (pv && !pr) begin
                    check("hold out_valid", out_valid, 1);
                    check("hold out_data", out_data, pd);
                    check("hold out_last", out_last, pl);
                end
                if (in_valid && in_ready && in_last) t_last = cyc;
                if (out_valid && !pv) begin
                    if (q_lat.size() == 0) unexpected("out_valid rise", out_data);
                    else check("latency", cyc - t_last, q_lat.pop_front());
                end
                if (out_valid && out_ready) begin
                    if (q_out.size() == 0) unexpected("out byte", out_data);
                    else begin
                        e9 = q_out.pop_front();
                        check("out_data", out_data, e9[7:0]);
                        check("out_last", out_last, e9[8]);
                    end
                end
                if (crc_data_valid) begin
                    if (run == 0 && have_run != 0) check("crc_data_valid gap>=2", gap >= 2, 1);
                    run++;
                    gap = 0;
                    if (q_crc.size() == 0) unexpected("crc_data", crc_data);
                    else check("crc_data", crc_data, q_crc.pop_front());
                end else begin
                    if (run != 0) begin
                        if (q_run.size() == 0) unexpected("crc run", run);
                        else check("crc_data_valid run length", run, q_run.pop_front());
                        have_run = 1;
                        run = 0;
                    end
                    gap++;
                end
                if (ovf) ovf_seen++;
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            end
        end
    end

    task automatic wait_accept();
        logic ok;
        int   t;
        t = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        check("input accept", ok, 1);
    endtask

    task automatic send_frame(input int n, input logic [15:0] exp_crc, input bit keep);
        if (keep) begin
            for (int i = 0; i < n; i++) begin
                q_out.push_back({1'b0, fb[i]});
                q_crc.push_back(fb[i]);
            end
            q_out.push_back({1'b0, exp_crc[15:8]});
            q_out.push_back({1'b1, exp_crc[7:0]});
            q_run.push_back(n);
            q_lat.push_back(n + 3);
        end
        for (int i = 0; i < n; i++) begin
            in_data  = fb[i];
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q_out.size() != 0 || out_valid) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain outstanding bytes", q_out.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int ovf0, t;
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset out_data", out_data, 0);
        check("reset crc_data", crc_data, 0);
        check("reset crc_data_valid", crc_data_valid, 0);
        check("reset ovf", ovf, 0);
`ifdef CRC16_FRAME_CNT_EN
        check("reset frame_cnt", frame_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("in_ready low in IDLE", in_ready, 0);
        @(negedge clk);
        check("in_ready high in FILL", in_ready, 1);
        @(posedge clk);
        #1;

        stub_mode = 1'b1;
        fb[0] = 8'h5A;
        send_frame(1, 16'hBEEF, 1);
        wait_drain();
        stub_mode = 1'b0;

        fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        send_frame(4, 16'h0000, 1);
        wait_drain();

        bp_mode = 1'b1;
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
        send_frame(3, 16'h6131, 1);
        wait_drain();
        bp_mode = 1'b0;

        ovf0 = ovf_seen;
        for (int i = 0; i < 6; i++) fb[i] = 8'hA0 + 8'(i);
        send_frame(6, 16'h0000, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ovf pulse count", ovf_seen - ovf0, 1);
        fb[0] = 8'h01; fb[1] = 8'h02;
        send_frame(2, 16'h1373, 1);
        wait_drain();

        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
        send_frame(4, 16'h0D03, 1);
        fb[0] = 8'h10; fb[1] = 8'h20;
        send_frame(2, 16'h2711, 1);
        wait_drain();
`ifdef CRC16_FRAME_CNT_EN
        check("frame_cnt after six frames", frame_cnt, 6);
`endif

        rdy_lvl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
        send_frame(3, 16'h0000, 1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reached SEND before reset", out_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset out_data", out_data, 0);
        check("async reset out_last", out_last, 0);
        check("async reset in_ready", in_ready, 0);
        check("async reset crc_data_valid", crc_data_valid, 0);
        q_out.delete(); q_crc.delete(); q_run.delete(); q_lat.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_lvl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fb[0] = 8'h01;
        send_frame(1, 16'h1021, 1);
        wait_drain();
`ifdef CRC16_FRAME_CNT_EN
        check("frame_cnt after reset and one frame", frame_cnt, 1);
`endif

        check("scoreboard empty", q_out.size() + q_crc.size() + q_run.size() + q_lat.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
